// File: rtl/washer_pkg.sv
// washer_pkg: shared door state encoding and plant error bit positions
package washer_pkg;
    typedef enum logic {DOOR_CLOSED = 1'b0, DOOR_OPEN = 1'b1} door_t;
    localparam int ERR_FILL_DRAIN = 0;
    localparam int ERR_SPIN_WET   = 1;
    localparam int ERR_WASH_DRY   = 2;
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: up/down counter saturating at 0 and MAX, with priority load
module sat_updown_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q <= '0;
        else if (load) q <= load_val;
        else if (inc && !dec && q < W'(MAX)) q <= q + 1'b1;
        else if (dec && !inc && q != '0) q <= q - 1'b1;
    end
endmodule

// File: rtl/washer_plant_model.sv
// washer_plant_model: cycle-based drum/water/moisture/door plant driven by the
// washer controller's actuator commands, with sticky illegal-command flags.
module washer_plant_model
    import washer_pkg::*;
#(
    parameter int LEVEL_MAX = 8,
    parameter int DRY_MAX   = 6,
    parameter int DOOR_MIN  = 4,
    localparam int LEVEL_W  = $clog2(LEVEL_MAX + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               water_fill,
    input  logic               motor_wash,
    input  logic               motor_spin,
    input  logic               drain,
    input  logic               door_req,
    input  logic               err_clr,
    output logic               water_full,
    output logic               drained,
    output logic               dry_sensor,
    output logic               door_open,
    output logic [LEVEL_W-1:0] water_level,
    output logic [2:0]         plant_err
);
    localparam int MW = $clog2(DRY_MAX + 1);
    localparam int DW = $clog2(DOOR_MIN + 1);

    logic [MW-1:0] moisture;
    logic [DW-1:0] cnt, cnt_nx;
    logic [2:0]    err_set;
    door_t         state, state_nx;

    sat_updown_counter #(.MAX(LEVEL_MAX), .W(LEVEL_W)) u_level (
        .clk(clk), .rstn(rstn),
        .inc(water_fill & ~drain), .dec(drain & ~water_fill),
        .load(1'b0), .load_val('0), .q(water_level)
    );

    // any water in the drum re-wets the load before spin can dry it
    sat_updown_counter #(.MAX(DRY_MAX), .W(MW)) u_moisture (
        .clk(clk), .rstn(rstn),
        .inc(1'b0), .dec(motor_spin),
        .load(water_level != '0), .load_val(MW'(DRY_MAX)), .q(moisture)
    );

    assign err_set[ERR_FILL_DRAIN] = water_fill & drain;
    assign err_set[ERR_SPIN_WET]   = motor_spin & (water_level != '0);
    assign err_set[ERR_WASH_DRY]   = motor_wash & (water_level == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) plant_err <= '0;
        else plant_err <= (err_clr ? 3'b000 : plant_err) | err_set;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= DOOR_CLOSED;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == DOOR_CLOSED) begin
            if (door_req) begin
                state_nx = DOOR_OPEN;
                cnt_nx   = DW'(DOOR_MIN - 1);
            end
        end else begin
            cnt_nx = (cnt != '0) ? cnt - 1'b1 : cnt;
            if (cnt == '0 && !door_req) state_nx = DOOR_CLOSED;
        end
    end

    assign water_full = water_level == LEVEL_W'(LEVEL_MAX);
    assign drained    = water_level == '0;
    assign dry_sensor = moisture == '0;
    assign door_open  = state == DOOR_OPEN;
endmodule

// File: tb/tb_washer_plant_model.sv
// tb_washer_plant_model: table-driven scoreboard bench for the washer plant model
module tb_washer_plant_model;
    localparam logic [5:0] F = 6'b100000, W = 6'b010000, S = 6'b001000,
                           D = 6'b000100, R = 6'b000010, C = 6'b000001, I = 6'b000000;

    typedef struct {
        logic [5:0] cmd;
        logic [3:0] lvl;
        logic       dry;
        logic       door;
        logic [2:0] err;
    } vec_t;

    logic clk = 1'b0, rstn = 1'b0;
    logic water_fill = 0, motor_wash = 0, motor_spin = 0, drain = 0, door_req = 0, err_clr = 0;
    logic water_full, drained, dry_sensor, door_open;
    logic [3:0] water_level;
    logic [2:0] plant_err;

    vec_t tbl[$];
    logic [10:0] sb[$];
    int checks = 0, passed = 0;

    washer_plant_model dut (
        .clk(clk), .rstn(rstn), .water_fill(water_fill), .motor_wash(motor_wash),
        .motor_spin(motor_spin), .drain(drain), .door_req(door_req), .err_clr(err_clr),
        .water_full(water_full), .drained(drained), .dry_sensor(dry_sensor),
        .door_open(door_open), .water_level(water_level), .plant_err(plant_err)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] pack_exp(logic [3:0] lvl, logic dry, logic door, logic [2:0] err);
        return {lvl, lvl == 4'd8, lvl == 4'd0, dry, door, err};
    endfunction

    function automatic void add(logic [5:0] cmd, int lvl, logic dry, logic door, logic [2:0] err);
        vec_t v;
        v.cmd = cmd; v.lvl = 4'(lvl); v.dry = dry; v.door = door; v.err = err;
        tbl.push_back(v);
    endfunction

    task automatic drive(logic [5:0] cmd);
        {water_fill, motor_wash, motor_spin, drain, door_req, err_clr} = cmd;
    endtask

    task automatic check(string name);
        logic [10:0] act, exp;
        act = {water_level, water_full, drained, dry_sensor, door_open, plant_err};
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty, got %b", name, act);
            checks++;
            return;
        end
        exp = sb.pop_front();
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got lvl=%0d full=%b drn=%b dry=%b door=%b err=%b, want lvl=%0d full=%b drn=%b dry=%b door=%b err=%b",
                      name, act[10:7], act[6], act[5], act[4], act[3], act[2:0],
                      exp[10:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    endtask

    task automatic step(logic [5:0] cmd, logic [10:0] exp, string name);
        @(negedge clk);
        drive(cmd);
        sb.push_back(exp);
        @(posedge clk);
        #1 check(name);
    endtask

    initial begin
        for (int i = 1; i <= 8; i++) add(F, i, i == 1, 0, 3'b000);
        add(F, 8, 0, 0, 3'b000);
        for (int i = 1; i <= 8; i++) add(D, 8 - i, 0, 0, 3'b000);
        add(D, 0, 0, 0, 3'b000);
        for (int i = 1; i <= 6; i++) add(S, 0, i == 6, 0, 3'b000);
        for (int i = 1; i <= 3; i++) add(F, i, i == 1, 0, 3'b000);
        add(F | D, 3, 0, 0, 3'b001);
        add(C, 3, 0, 0, 3'b000);
        add(D, 2, 0, 0, 3'b000);
        add(S, 2, 0, 0, 3'b010);
        add(D, 1, 0, 0, 3'b010);
        add(D, 0, 0, 0, 3'b010);
        add(W, 0, 0, 0, 3'b110);
        add(I, 0, 0, 0, 3'b110);
        add(C, 0, 0, 0, 3'b000);
        add(C | W, 0, 0, 0, 3'b100);
        add(C, 0, 0, 0, 3'b000);
        add(R, 0, 0, 1, 3'b000);
        for (int i = 0; i < 3; i++) add(I, 0, 0, 1, 3'b000);
        add(I, 0, 0, 0, 3'b000);
        for (int i = 0; i < 10; i++) add(R, 0, 0, 1, 3'b000);
        add(I, 0, 0, 0, 3'b000);
        add(I, 0, 0, 0, 3'b000);

        repeat (2) @(posedge clk);
        #1 sb.push_back(pack_exp(4'd0, 1'b1, 1'b0, 3'b000));
        check("reset_state");
        @(negedge clk) rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].cmd, pack_exp(tbl[i].lvl, tbl[i].dry, tbl[i].door, tbl[i].err), $sformatf("vec%0d", i));

        // reset mid-operation: level 5, door open, then rstn drops between edges
        for (int i = 1; i <= 5; i++) step(F, pack_exp(4'(i), 1'b0, 1'b0, 3'b000), "refill");
        step(R | S, pack_exp(4'd5, 1'b0, 1'b1, 3'b010), "door_open_wet");
        #2 rstn = 1'b0;
        #1 sb.push_back(pack_exp(4'd0, 1'b1, 1'b0, 3'b000));
        check("async_reset");
        drive(F | R);
        @(posedge clk);
        #1 sb.push_back(pack_exp(4'd0, 1'b1, 1'b0, 3'b000));
        check("reset_held");
        @(negedge clk) begin rstn = 1'b1; drive(I); end
        step(I, pack_exp(4'd0, 1'b1, 1'b0, 3'b000), "after_reset");
        step(F, pack_exp(4'd1, 1'b1, 1'b0, 3'b000), "fill_after_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
- Cycle-based behavioural model of the washing-machine plant: the drum, water, load moisture and door.
- Consumes the actuator commands the washer controller drives (water_fill, motor_wash, motor_spin, drain).
- Produces the sensor signals the controller consumes (water_full, drained, dry_sensor, door_open).
- Sits opposite the controller in closed-loop benches, and on the demo top as a stand-in for real hardware. Also flags physically illegal command combinations.

Parameters:
LEVEL_MAX, 8, fill cycles from empty to full; drain empties at 1 level/cycle
DRY_MAX, 6, spin cycles (drum empty) needed to dry a wet load
DOOR_MIN, 4, minimum cycles the door stays open once opened
LEVEL_W, $clog2(LEVEL_MAX+1), width of water_level (derived, do not override)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
water_fill  in  1  fill valve command
motor_wash  in  1  wash-motor command
motor_spin  in  1  spin-motor command
drain  in  1  drain pump command
door_req  in  1  user/bench request to open the door (level)
err_clr  in  1  synchronous clear of the sticky error flags
water_full  out  1  level == LEVEL_MAX
drained  out  1  level == 0
dry_sensor  out  1  moisture == 0
door_open  out  1  door state is OPEN
water_level  out  LEVEL_W  current water level, for observation
plant_err  out  3  sticky flags: [0] fill and drain together, [1] spin with water present, [2] wash with empty drum

Behaviour:
- Reset (rstn low, asynchronous):
  - level = 0, moisture = 0, door = CLOSED, door counter = 0, plant_err = 0.
  - Outputs therefore reset to: drained=1, water_full=0, dry_sensor=1, door_open=0, water_level=0.
- All sensor outputs are combinational decodes of registered state. A command sampled at edge k is visible on the outputs after edge k.
- Level update, per edge:
  - fill & !drain & level < LEVEL_MAX: level + 1.
  - drain & !fill & level > 0: level - 1.
  - fill & drain: level holds and plant_err[0] is set.
  - Otherwise: hold.
  - Level saturates at 0 and at LEVEL_MAX, never wraps.
- Moisture update, priority order:
  - level > 0 (pre-update value): moisture loads DRY_MAX.
  - Else motor_spin & moisture > 0: moisture - 1.
  - Else: hold.
  - Saturates at 0.
- Error flags:
  - plant_err[1] sets on motor_spin & level > 0.
  - plant_err[2] sets on motor_wash & level == 0.
  - Flags are sticky. err_clr clears them on the next edge. If err_clr and a new set condition occur in the same cycle, set wins.
- Door FSM:
  - States: CLOSED, OPEN.
  - CLOSED -> OPEN on door_req; door counter loads DOOR_MIN-1.
  - OPEN: counter decrements to 0 and saturates there. OPEN -> CLOSED when counter == 0 and !door_req.
  - door_req held high keeps the door OPEN indefinitely.
  - There is no interlock: the door opens regardless of level. Modelling the user forcing it, and the controller's resulting fault path, is intentional.
  - Door state does not affect level or moisture.
- Commands are not gated by door_open. The model reflects whatever the controller drives.
- Reset mid-operation returns to the reset values immediately, regardless of state.

Decomposition:
- Shared package washer_pkg holds:
  - Door state enum (DOOR_CLOSED=1'b0, DOOR_OPEN=1'b1).
  - plant_err bit-index constants (ERR_FILL_DRAIN=0, ERR_SPIN_WET=1, ERR_WASH_DRY=2).
- One sub-module, sat_updown_counter:
  - Parameters MAX, W; ports clk, rstn, inc, dec, load, load_val, q.
  - Saturating at 0 and MAX; inc and dec together means hold.
  - Instantiated twice, for level and moisture.
- Door FSM and error flags stay in the top module.

Test Plan:
- Reset, then water_fill=1 for 8 cycles -> water_level steps 1..8; water_full=1 after the 8th edge; a 9th fill cycle keeps level=8; drained=0 from the first edge.
- From level 8, drain=1 for 8 cycles -> level 0, drained=1 after the 8th edge. During those cycles moisture holds 6 and dry_sensor=0. Further drain keeps level 0.
- Level 0, moisture 6, motor_spin=1 -> dry_sensor=1 exactly 6 edges later, plant_err=0.
- water_fill=1 and drain=1 together at level 3 -> level stays 3, plant_err=3'b001. err_clr pulse -> plant_err=0 next edge.
- motor_spin=1 at level 2 -> plant_err[1]=1. motor_wash=1 at level 0 -> plant_err[2]=1. Both flags persist until err_clr.
- door_req 1-cycle pulse -> door_open=1 for exactly 4 cycles. door_req held 10 cycles -> open 10 cycles, closes the edge after release. rstn low at level 5 while OPEN -> level 0, drained=1, door_open=0 asynchronously.
